lc3_mem_ctrl: RTL and testbench

- Memory-access unit for the LC-3 datapath; it is the producer side of the shared 16-bit bus that the register file consumes.
- Holds MAR and MDR and runs the MIO.EN / R.W / R handshake between the control FSM and an external memory with variable wait states.
- Drives loaded data back onto the bus through GateMDR so it can be written to a register.

---
 rtl/lc3_mem_ctrl.sv | 112 +++++++++++
 tb/tb_lc3_mem_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-access unit: owns MAR/MDR and runs the MIO.EN / R.W / R handshake
// with a variable-latency memory, abandoning an access after TIMEOUT wait cycles.
module lc3_mem_ctrl #(
    parameter int          TIMEOUT  = 16,
    parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_in,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic        gate_mdr,
    output logic [15:0] mdr_out,
    output logic [15:0] mar_out,
    output logic        ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_HOLD
    } state_t;

    state_t         r_state;
    logic [15:0]    r_mar;
    logic [15:0]    r_mdr;
    logic [CW-1:0]  r_cnt;
    logic           r_req;
    logic           r_we;
    logic           r_ready;
    logic           r_err;
    logic           w_loads_ok;

    // MAR/MDR are frozen while the memory owns the address and write data
    assign w_loads_ok = (r_state != S_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mar   <= 16'h0000;
            r_mdr   <= 16'h0000;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_loads_ok && ld_mar) r_mar <= bus_in;
            if (w_loads_ok && ld_mdr) r_mdr <= bus_in;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (mio_en) begin
                        r_we    <= r_w;
                        r_req   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        if (!r_we) r_mdr <= mem_rdata;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        if (!r_we) r_mdr <= ERR_DATA;
                        r_err   <= 1'b1;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_state <= mio_en ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    // one mio_en assertion yields exactly one access
                    if (!mio_en) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mdr_out   = gate_mdr ? r_mdr : 16'h0000;
    assign mar_out   = r_mar;
    assign ready     = r_ready;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_mar;
    assign mem_wdata = r_mdr;
    assign err       = r_err;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: read, write with waits, timeout, held mio_en,
// loads during WAIT and reset mid-access, all against hand-computed values.
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_in;
    logic        ld_mar, ld_mdr, mio_en, r_w, gate_mdr;
    logic [15:0] mdr_out, mar_out;
    logic        ready, mem_req, mem_we, err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lc3_mem_ctrl #(.TIMEOUT(4), .ERR_DATA(16'hDEAD)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en), .r_w(r_w), .gate_mdr(gate_mdr), .mdr_out(mdr_out),
        .mar_out(mar_out), .ready(ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int req_cnt;
        int rdy_cnt;
        rst = 1'b1; bus_in = 16'h0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
        gate_mdr = 1'b1; mem_rdata = 16'h0; mem_ack = 0;
        step(); step();
        rst = 1'b0;
        chk("rst_req", mem_req, 0);
        chk("rst_ready", ready, 0);
        chk("rst_err", err, 0);
        chk("rst_mar", mar_out, 16'h0000);
        chk("rst_mdr", mdr_out, 16'h0000);
        $display("txn reset done");

        // Read, zero wait
        ld_mar = 1; bus_in = 16'h3000; step();
        ld_mar = 0;
        chk("rd_mar", mar_out, 16'h3000);
        mio_en = 1; r_w = 0; step();
        mio_en = 0;
        chk("rd_req", mem_req, 1);
        chk("rd_we", mem_we, 0);
        chk("rd_addr", mem_addr, 16'h3000);
        chk("rd_ready_early", ready, 0);
        mem_ack = 1; mem_rdata = 16'h1234; step();
        mem_ack = 0;
        chk("rd_ready", ready, 1);
        chk("rd_req_drop", mem_req, 0);
        gate_mdr = 0; #1;
        chk("rd_gate0", mdr_out, 16'h0000);
        gate_mdr = 1; #1;
        chk("rd_mdr", mdr_out, 16'h1234);
        step();
        chk("rd_ready_pulse", ready, 0);
        $display("txn read zero-wait done");

        // Write, 3 wait cycles; MDR load in the same cycle as mio_en; MAR load mid-WAIT ignored
        ld_mar = 1; bus_in = 16'h4001; step();
        ld_mar = 0; ld_mdr = 1; bus_in = 16'hBEEF; mio_en = 1; r_w = 1; step();
        ld_mdr = 0; mio_en = 0; r_w = 0;
        for (int i = 0; i < 4; i++) begin
            chk("wr_req", mem_req, 1);
            chk("wr_we", mem_we, 1);
            chk("wr_addr", mem_addr, 16'h4001);
            chk("wr_wdata", mem_wdata, 16'hBEEF);
            chk("wr_ready_early", ready, 0);
            ld_mar = (i == 1); bus_in = 16'h5555;
            mem_ack = (i == 3); mem_rdata = 16'h9999;
            step();
        end
        ld_mar = 0; mem_ack = 0;
        chk("wr_ready", ready, 1);
        chk("wr_req_drop", mem_req, 0);
        chk("wr_mdr_kept", mdr_out, 16'hBEEF);
        chk("wr_mar_frozen", mar_out, 16'h4001);
        step();
        ld_mar = 1; bus_in = 16'h5555; step();
        ld_mar = 0;
        chk("idle_ld_mar", mar_out, 16'h5555);
        $display("txn write 3-wait done");

        // Timeout read, no ack
        mio_en = 1; r_w = 0; step();
        mio_en = 0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req", mem_req, 1);
            step();
        end
        chk("to_ready", ready, 1);
        chk("to_req_drop", mem_req, 0);
        chk("to_err", err, 1);
        chk("to_mdr", mdr_out, 16'hDEAD);
        step();
        chk("to_ready_pulse", ready, 0);
        $display("txn timeout done");

        // Held mio_en with immediate ack: one access only
        mio_en = 1; mem_ack = 1; mem_rdata = 16'h0042;
        req_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            req_cnt += int'(mem_req);
            rdy_cnt += int'(ready);
        end
        chk("hold_req_count", req_cnt, 1);
        chk("hold_ready_count", rdy_cnt, 1);
        chk("hold_mdr", mdr_out, 16'h0042);
        chk("hold_err_sticky", err, 1);
        mio_en = 0; step();
        mio_en = 1; mem_rdata = 16'h0043; step();
        chk("hold_req2", mem_req, 1);
        mio_en = 0; step();
        chk("hold_ready2", ready, 1);
        chk("hold_mdr2", mdr_out, 16'h0043);
        mem_ack = 0; step();
        $display("txn held mio_en done");

        // Reset mid-WAIT; a late ack is ignored
        ld_mdr = 1; bus_in = 16'h7777; step();
        ld_mdr = 0; mio_en = 1; r_w = 0; step();
        mio_en = 0;
        chk("rw_req_before", mem_req, 1);
        rst = 1; step();
        rst = 0;
        chk("rw_req", mem_req, 0);
        chk("rw_ready", ready, 0);
        chk("rw_mar", mar_out, 16'h0000);
        chk("rw_mdr", mdr_out, 16'h0000);
        chk("rw_err", err, 0);
        mem_ack = 1; mem_rdata = 16'hABCD; step();
        mem_ack = 0;
        chk("rw_late_req", mem_req, 0);
        chk("rw_late_ready", ready, 0);
        chk("rw_late_mdr", mdr_out, 16'h0000);
        mio_en = 1; step();
        mio_en = 0;
        chk("rw_idle_restart", mem_req, 1);
        $display("txn reset mid-wait done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
